imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Boot-time loader and address arbiter for the 256-entry, 32-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into one little-endian instruction word.
- Writes each word into the memory write port at consecutive addresses starting at 0, holding the CPU in stall while the load is in progress.
- When idle, passes the CPU PC address straight through to the memory read address. When a load completes, pulses a CPU restart request so execution begins at address 0.

Parameters:
- ADDR_W, 8, instruction memory address width (depth = 2^ADDR_W words).
- LEN_W, 9, width of the load length field (ADDR_W+1, so a full-depth load is representable).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  one-cycle load start; sampled only in IDLE.
- load_len  in  LEN_W  number of words to load; sampled with load_req.
- load_abort  in  1  terminates an active load.
- byte_valid  in  1  byte source has data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- pc_addr  in  ADDR_W  CPU fetch address.
- mem_addr  out  ADDR_W  memory address (read in IDLE, write otherwise).
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  assembled word.
- cpu_hold  out  1  CPU stall.
- cpu_restart  out  1  one-cycle request to reset the CPU PC to 0.
- load_done  out  1  one-cycle completion pulse.
- load_err  out  1  one-cycle abort pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, RECV, WRITE, DONE.
- Reset, applied in any state:
  - State goes to IDLE; word_idx, byte_cnt and the assembly register clear to 0.
  - All registered outputs are 0: byte_ready, mem_we, mem_wdata, cpu_hold, cpu_restart, load_done, load_err, busy.
  - A load in progress when reset is taken is lost; the memory keeps whatever words were already written.
- IDLE:
  - mem_addr = pc_addr (combinational pass-through); cpu_hold = 0.
  - load_req with load_len = 0: go to DONE directly; no writes occur.
  - load_req with load_len in 1..2^ADDR_W: latch the length, clear word_idx and byte_cnt, go to RECV.
  - load_len > 2^ADDR_W is clamped to 2^ADDR_W.
  - load_req in any other state is ignored.
- RECV:
  - byte_ready = 1; cpu_hold = 1; mem_addr = word_idx.
  - A byte transfers on a cycle where byte_valid and byte_ready are both high.
  - Byte n of a word (n = byte_cnt, 0..3) is stored into bits [8n+7:8n].
  - byte_cnt increments on each transfer. On the 4th transfer, byte_cnt wraps to 0 and the state moves to WRITE.
  - byte_valid low: state holds, no change.
- WRITE:
  - Exactly one cycle: mem_we = 1, mem_wdata = assembled word, mem_addr = word_idx, byte_ready = 0.
  - If word_idx = len-1, go to DONE. Otherwise word_idx increments and the state returns to RECV.
  - Throughput: one word per 5 cycles minimum (4 byte cycles + 1 write cycle).
- DONE:
  - Exactly one cycle: load_done = 1, cpu_restart = 1, cpu_hold = 1. Then go to IDLE.
  - cpu_hold falls the cycle after cpu_restart.
- load_abort:
  - Honoured in RECV only: go to IDLE, pulse load_err for one cycle, clear byte_cnt, no cpu_restart.
  - Ignored in WRITE and DONE (those states are single-cycle).
  - If load_abort and a byte handshake occur in the same cycle, the abort wins and the byte is dropped.
- busy = 1 in RECV, WRITE and DONE.
- word_idx is ADDR_W+1 bits internally; mem_addr takes its low ADDR_W bits, so a full-depth load ends at address 255 and never wraps onto address 0.

Test Plan:
- Reset, then pc_addr = 8'h2A: mem_addr = 8'h2A, cpu_hold = 0, all pulse outputs 0.
- load_req with len = 2, bytes 13,00,00,00 then 93,02,10,00: writes 32'h00000013 at address 0 and 32'h00100293 at address 1, each with a single-cycle mem_we. Then load_done and cpu_restart pulse together, and cpu_hold drops the next cycle.
- Same load with byte_valid toggling every other cycle: identical writes, byte_ready held high throughout RECV, and no bytes lost or duplicated.
- load_req with len = 0: DONE on the next cycle, load_done = 1, mem_we never asserted.
- Full load with len = 256: the last write lands at address 8'hFF, the state goes to DONE, and address 0 is not rewritten. A second load_req issued mid-load is ignored.
- load_abort after 6 bytes: load_err pulses, the state returns to IDLE, only address 0 has been written, and cpu_restart stays 0. A separate run asserting rst mid-RECV returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot loader that packs a byte stream into little-endian words for the
// instruction memory and arbitrates its address port between the loader and the CPU.
module imem_load_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req_i,
    input  logic [LEN_W-1:0]  load_len_i,
    input  logic              load_abort_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic [ADDR_W-1:0] pc_addr_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              cpu_restart_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_req_i) begin
                    len_d      = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    state_d    = (load_len_i == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                // abort outranks a same-cycle byte handshake, so that byte is dropped
                if (load_abort_i) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                end else if (byte_valid_i) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = (byte_cnt_q == 2'd3) ? WRITE : RECV;
                end
            end
            WRITE: begin
                if (word_idx_q == len_q - LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + LEN_W'(1);
                    state_d    = RECV;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    assign byte_ready_o  = (state_q == RECV);
    assign mem_we_o      = (state_q == WRITE);
    assign mem_wdata_o   = asm_q;
    assign mem_addr_o    = (state_q == IDLE) ? pc_addr_i : word_idx_q[ADDR_W-1:0];
    assign cpu_hold_o    = (state_q != IDLE);
    assign busy_o        = (state_q != IDLE);
    assign cpu_restart_o = (state_q == DONE);
    assign load_done_o   = (state_q == DONE);
    assign load_err_o    = err_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: randomized loads checked by a write/event scoreboard and a memory image model.
module tb_imem_load_ctrl;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_req = 1'b0;
    logic [LEN_W-1:0]  load_len = '0;
    logic              load_abort = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready_o;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic              cpu_hold_o;
    logic              cpu_restart_o;
    logic              load_done_o;
    logic              load_err_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    wr_t        exp_wr_q[$];
    int         exp_evt_q[$];
    logic [7:0] preset[$];
    logic [31:0] exp_mem [256];
    logic [31:0] shadow  [256];
    int         full_writes = 0;

    imem_load_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .load_req_i(load_req), .load_len_i(load_len), .load_abort_i(load_abort),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready_o),
        .pc_addr_i(pc_addr), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .cpu_hold_o(cpu_hold_o), .cpu_restart_o(cpu_restart_o),
        .load_done_o(load_done_o), .load_err_o(load_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals completion.
    initial begin
        wr_t e;
        logic prev_restart;
        prev_restart = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we_o) begin
                    full_writes++;
                    shadow[mem_addr_o] = mem_wdata_o;
                    if (exp_wr_q.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        e = exp_wr_q.pop_front();
                        chk("write_addr", mem_addr_o, e.a);
                        chk("write_data", mem_wdata_o, e.d);
                    end
                end
                if (load_done_o) chk("done_event", EV_DONE, (exp_evt_q.size() != 0) ? exp_evt_q.pop_front() : 0);
                if (load_err_o)  chk("err_event", EV_ERR, (exp_evt_q.size() != 0) ? exp_evt_q.pop_front() : 0);
                if (load_done_o || cpu_restart_o) chk("restart_with_done", cpu_restart_o, load_done_o);
                if (prev_restart) chk("hold_drop_after_restart", cpu_hold_o, 0);
            end
            prev_restart = cpu_restart_o && !rst;
        end
    end

    // abort_at / rst_at: byte index at which to abort or reset (-1 = never).
    // gap_mode: 0 no gaps, 1 valid toggles every other cycle, 2 random gaps.
    task automatic do_load(input int len, input int abort_at, input int rst_at,
                           input int gap_mode, input int req_word);
        logic [7:0] b[$];
        int words, cut, gaps;
        words = (len > 256) ? 256 : len;
        for (int i = 0; i < words * 4; i++)
            b.push_back((preset.size() != 0) ? preset.pop_front() : 8'($urandom));
        cut = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : words * 4;
        for (int w = 0; w < cut / 4; w++) begin
            exp_wr_q.push_back('{a: 8'(w), d: {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}});
            exp_mem[w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
        end
        if (abort_at >= 0) exp_evt_q.push_back(EV_ERR);
        else if (rst_at < 0) exp_evt_q.push_back(EV_DONE);
        @(negedge clk);
        load_req = 1'b1;
        load_len = LEN_W'(len);
        @(negedge clk);
        load_req = 1'b0;
        for (int w = 0; w < words; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k == abort_at) begin
                    load_abort = 1'b1;
                    byte_valid = 1'b1;
                    byte_data  = 8'($urandom);
                    #1 chk("ready_at_abort", byte_ready_o, 1);
                    @(negedge clk);
                    load_abort = 1'b0;
                    byte_valid = 1'b0;
                    #1 chk("idle_after_abort", busy_o, 0);
                    chk("no_restart_on_abort", cpu_restart_o, 0);
                    @(negedge clk);
                    #1 chk("err_single_pulse", load_err_o, 0);
                    return;
                end
                if (4 * w + k == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    #1 chk("rst_outputs", {byte_ready_o, mem_we_o, cpu_hold_o, cpu_restart_o,
                                           load_done_o, load_err_o, busy_o}, 0);
                    chk("rst_wdata", mem_wdata_o, 0);
                    chk("rst_addr_passthru", mem_addr_o, pc_addr);
                    rst = 1'b0;
                    return;
                end
                gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
                repeat (gaps) begin
                    byte_valid = 1'b0;
                    #1 chk("ready_in_gap", {byte_ready_o, mem_we_o}, 2'b10);
                    @(negedge clk);
                end
                byte_valid = 1'b1;
                byte_data  = b[4*w+k];
                if (w == req_word && k == 0) begin
                    load_req = 1'b1;
                    load_len = LEN_W'(3);
                end
                #1 chk("ready_on_byte", {byte_ready_o, mem_we_o}, 2'b10);
                @(negedge clk);
                load_req = 1'b0;
            end
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            #1 chk("write_cycle", {byte_ready_o, mem_we_o}, 2'b01);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        #1 chk("done_cycle", {load_done_o, cpu_restart_o, cpu_hold_o, mem_we_o}, 4'b1110);
        @(negedge clk);
        pc_addr = 8'($urandom);
        #1 chk("idle_after_done", {cpu_hold_o, busy_o, load_done_o}, 0);
        chk("idle_addr_passthru", mem_addr_o, pc_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = '0;
            shadow[i]  = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pc_addr = 8'h2A;
        #1 chk("reset_addr", mem_addr_o, 8'h2A);
        chk("reset_outputs", {byte_ready_o, mem_we_o, cpu_hold_o, cpu_restart_o,
                              load_done_o, load_err_o, busy_o}, 0);
        chk("reset_wdata", mem_wdata_o, 0);

        preset = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
        do_load(2, -1, -1, 0, -1);
        chk("word0_image", shadow[0], 32'h00000013);
        chk("word1_image", shadow[1], 32'h00100293);

        preset = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
        do_load(2, -1, -1, 1, -1);

        full_writes = 0;
        do_load(0, -1, -1, 0, -1);
        chk("len0_no_writes", full_writes, 0);

        repeat (5) do_load($urandom_range(1, 6), -1, -1, 2, -1);

        full_writes = 0;
        do_load(256, -1, -1, 2, 10);
        chk("full_load_writes", full_writes, 256);

        full_writes = 0;
        do_load(511, -1, -1, 0, -1);
        chk("clamped_load_writes", full_writes, 256);

        full_writes = 0;
        do_load(3, 6, -1, 0, -1);
        chk("abort_writes", full_writes, 1);

        do_load(4, -1, 9, 2, -1);
        do_load(2, -1, -1, 0, -1);

        repeat (3) @(negedge clk);
        chk("writes_outstanding", exp_wr_q.size(), 0);
        chk("events_outstanding", exp_evt_q.size(), 0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (shadow[i] !== exp_mem[i]) bad++;
            chk("memory_image_mismatches", bad, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
